sump_cmd_tx: RTL

//  Host-side SUMP command serializer: the other end of the analyzer's command receiver.

---
 rtl/sump_cmd_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sump_cmd_tx.sv
// SUMP host-side command serializer: sends {data, opcode} as 8N1 UART frames,
// opcode first, then data bytes LSB-first for long commands (opcode[7]=1).
// Optional XOFF flow control at byte boundaries: define SUMP_CMD_TX_FLOW_EN.
module sump_cmd_tx #(
  parameter int FREQ = 100000000,
  parameter int RATE = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [39:0] cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        uart_tx
`ifdef SUMP_CMD_TX_FLOW_EN
  ,
  input  logic        pause
`endif
);

  localparam int DIVISOR = FREQ / RATE;
  localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  generate
    if (DIVISOR < 2) begin : g_divisor_check
      $error("sump_cmd_tx: FREQ/RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef SUMP_CMD_TX_FLOW_EN
    ,
    S_HOLD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [39:0]      cmd_q, cmd_d;
  logic             long_q, long_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]       cur_byte;
  logic             cnt_wrap;
  logic             last_byte;

  // Byte k of the latched command is cmd[8k+7:8k]: opcode, then data LSB-first.
  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = cmd_q[7:0];
      3'd1:    cur_byte = cmd_q[15:8];
      3'd2:    cur_byte = cmd_q[23:16];
      3'd3:    cur_byte = cmd_q[31:24];
      default: cur_byte = cmd_q[39:32];
    endcase
  end

  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign last_byte = (byte_q == (long_q ? 3'd4 : 3'd0));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cmd_d   = cmd_q;
    long_d  = long_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd;
          long_d = cmd[7];
          byte_d = 3'd0;
          bit_d  = 3'd0;
          cnt_d  = '0;
          busy_d = 1'b1;
`ifdef SUMP_CMD_TX_FLOW_EN
          if (pause) begin
            state_d = S_HOLD;
            tx_d    = 1'b1;
          end else
`endif
          begin
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
      end

      S_START: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (last_byte) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            byte_d = byte_q + 3'd1;
            bit_d  = 3'd0;
            // Next start bit follows the stop bit with no idle gap unless the far end paused us.
`ifdef SUMP_CMD_TX_FLOW_EN
            if (pause) begin
              state_d = S_HOLD;
              tx_d    = 1'b1;
            end else
`endif
            begin
              state_d = S_START;
              tx_d    = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SUMP_CMD_TX_FLOW_EN
      S_HOLD: begin
        cnt_d = '0;
        if (!pause) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous and active-low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      cmd_q   <= '0;
      long_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cmd_q   <= cmd_d;
      long_q  <= long_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign uart_tx   = tx_q;

endmodule
